// File: rtl/io_share_arbiter.sv
// io_share_arbiter: hands a shared bank of user I/O pads back and forth
// between the GPIO controller and the simplebus external-bus master.
// Every handover tristates all pads for a turnaround window. A minimum-hold
// timer keeps a toggling request from thrashing ownership.
module io_share_arbiter #(
  parameter int NPINS       = 19,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_MIN    = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             bus_req,
  input  logic [NPINS-1:0] gpio_out,
  input  logic [NPINS-1:0] gpio_dir,
  input  logic [NPINS-1:0] bus_pin_out,
  input  logic [NPINS-1:0] bus_pin_oeb,
  output logic [NPINS-1:0] io_out,
  output logic [NPINS-1:0] io_oeb,
  output logic             bus_gnt,
  output logic             gpio_gnt,
  output logic             turning
);

  localparam int TW = $clog2(TURN_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_MIN) + 1;

  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_MIN - 1);
  localparam logic [TW-1:0] TURN_ONE  = TW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    GPIO         = 2'd0,
    TURN_TO_BUS  = 2'd1,
    BUS          = 2'd2,
    TURN_TO_GPIO = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    turn_cnt, turn_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [NPINS-1:0] pad_out_nxt, pad_oeb_nxt;

  // State, counters and pad registers all update on the same edge, so the
  // pads always reflect the owner that the state register now names.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= GPIO;
      turn_cnt <= '0;
      hold_cnt <= '0;
      io_out   <= '0;
      io_oeb   <= '1;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_nxt;
      hold_cnt <= hold_nxt;
      io_out   <= pad_out_nxt;
      io_oeb   <= pad_oeb_nxt;
    end
  end

  // Ownership sequencing: a handover starts only once the hold timer has
  // expired, and a turnaround always runs to completion once started.
  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    hold_nxt  = hold_cnt;
    case (state)
      GPIO: begin
        if (bus_req && (hold_cnt == '0)) begin
          state_nxt = TURN_TO_BUS;
          turn_nxt  = TURN_LOAD;
        end else if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - HOLD_ONE;
        end
      end
      TURN_TO_BUS: begin
        if (turn_cnt == '0) begin
          state_nxt = BUS;
          hold_nxt  = HOLD_LOAD;
        end else begin
          turn_nxt = turn_cnt - TURN_ONE;
        end
      end
      BUS: begin
        if (!bus_req && (hold_cnt == '0)) begin
          state_nxt = TURN_TO_GPIO;
          turn_nxt  = TURN_LOAD;
        end else if (hold_cnt != '0) begin
          hold_nxt = hold_cnt - HOLD_ONE;
        end
      end
      TURN_TO_GPIO: begin
        if (turn_cnt == '0) begin
          state_nxt = GPIO;
          hold_nxt  = HOLD_LOAD;
        end else begin
          turn_nxt = turn_cnt - TURN_ONE;
        end
      end
      default: begin
        state_nxt = GPIO;
      end
    endcase
  end

  // Pad values are chosen by the state being entered, so a turnaround
  // tristates the pads on the very edge that begins it.
  always_comb begin
    pad_out_nxt = '0;
    pad_oeb_nxt = '1;
    case (state_nxt)
      GPIO: begin
        pad_out_nxt = gpio_out;
        pad_oeb_nxt = ~gpio_dir;
      end
      BUS: begin
        pad_out_nxt = bus_pin_out;
        pad_oeb_nxt = bus_pin_oeb;
      end
      default: begin
        pad_out_nxt = '0;
        pad_oeb_nxt = '1;
      end
    endcase
  end

  // Status flags decode the current state, lining up with the pad registers.
  always_comb begin
    gpio_gnt = (state == GPIO);
    bus_gnt  = (state == BUS);
    turning  = (state == TURN_TO_BUS) || (state == TURN_TO_GPIO);
  end

endmodule

// File: tb/tb_io_share_arbiter.sv
// Scoreboard bench for io_share_arbiter: the stimulus process pushes the
// hand-derived expected response for each edge, and a monitor pops and
// compares just after that edge.
module tb_io_share_arbiter;

  localparam int NP = 19;

  localparam logic [2:0] S_G = 3'b100;  // {gpio_gnt, bus_gnt, turning}
  localparam logic [2:0] S_B = 3'b010;
  localparam logic [2:0] S_T = 3'b001;

  localparam logic [NP-1:0] ALL  = 19'h7FFFF;
  localparam logic [NP-1:0] GO1  = 19'h12345;
  localparam logic [NP-1:0] GO2  = 19'h0ABCD;
  localparam logic [NP-1:0] BO1  = 19'h5A5A5;
  localparam logic [NP-1:0] BO2  = 19'h13579;
  localparam logic [NP-1:0] BOE1 = 19'h7FC00;

  typedef struct {
    logic [2:0]    st;
    logic [NP-1:0] out;
    logic [NP-1:0] oeb;
    string         name;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          bus_req;
  logic [NP-1:0] gpio_out;
  logic [NP-1:0] gpio_dir;
  logic [NP-1:0] bus_pin_out;
  logic [NP-1:0] bus_pin_oeb;
  logic [NP-1:0] io_out;
  logic [NP-1:0] io_oeb;
  logic          bus_gnt;
  logic          gpio_gnt;
  logic          turning;

  exp_t expq[$];
  int   checks = 0;
  int   passes = 0;

  io_share_arbiter #(.NPINS(NP), .TURN_CYCLES(2), .HOLD_MIN(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .bus_req     (bus_req),
    .gpio_out    (gpio_out),
    .gpio_dir    (gpio_dir),
    .bus_pin_out (bus_pin_out),
    .bus_pin_oeb (bus_pin_oeb),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .bus_gnt     (bus_gnt),
    .gpio_gnt    (gpio_gnt),
    .turning     (turning)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one edge's inputs on the falling edge and queues the response
  // expected right after the following rising edge.
  task automatic applyStimulus(input logic r, input logic req,
                               input logic [NP-1:0] g_out, input logic [NP-1:0] g_dir,
                               input logic [NP-1:0] b_out, input logic [NP-1:0] b_oeb,
                               input logic [2:0] e_st, input logic [NP-1:0] e_out,
                               input logic [NP-1:0] e_oeb, input string nm);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus_req     = req;
    gpio_out    = g_out;
    gpio_dir    = g_dir;
    bus_pin_out = b_out;
    bus_pin_oeb = b_oeb;
    e.st  = e_st;
    e.out = e_out;
    e.oeb = e_oeb;
    e.name = nm;
    expq.push_back(e);
    @(posedge clk);
  endtask

  // Compares status flags and pad registers against one expected entry.
  task automatic checkOutput(input exp_t e);
    checks++;
    if ({gpio_gnt, bus_gnt, turning} === e.st) passes++;
    else $display("[TB] FAIL %s status: got %b required %b", e.name,
                  {gpio_gnt, bus_gnt, turning}, e.st);
    checks++;
    if (io_out === e.out && io_oeb === e.oeb) passes++;
    else $display("[TB] FAIL %s pads: got out=%h oeb=%h required out=%h oeb=%h",
                  e.name, io_out, io_oeb, e.out, e.oeb);
  endtask

  // Monitor: every rising edge with an outstanding expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    string pat;
    logic  req;
    logic [2:0]    st;
    logic [NP-1:0] eo, eb;
    rst = 1'b1; bus_req = 1'b0;
    gpio_out = '0; gpio_dir = '0; bus_pin_out = '0; bus_pin_oeb = '1;

    // Reset and GPIO ownership.
    applyStimulus(1, 0, GO1, ALL, BO1, BOE1, S_G, '0, ALL, "reset0");
    applyStimulus(1, 0, GO1, ALL, BO1, BOE1, S_G, '0, ALL, "reset1");
    applyStimulus(0, 0, GO1, ALL, BO1, BOE1, S_G, GO1, '0, "gpio_first");
    applyStimulus(0, 0, 19'h7FFFF, 19'h0000F, BO1, BOE1, S_G, 19'h7FFFF, 19'h7FFF0, "gpio_dir");

    // Handover to the bus: two tristated edges, then bus pads.
    applyStimulus(0, 1, GO1, ALL, BO1, BOE1, S_T, '0, ALL, "to_bus_t1");
    applyStimulus(0, 1, GO1, ALL, BO1, BOE1, S_T, '0, ALL, "to_bus_t2");
    applyStimulus(0, 1, GO1, ALL, BO1, BOE1, S_B, BO1, BOE1, "bus_gnt");

    // GPIO changes while the bus owns the pads must not appear.
    applyStimulus(0, 1, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "bus_hold1");
    applyStimulus(0, 1, GO2, ALL, BO2, BOE1, S_B, BO2, BOE1, "bus_track");
    applyStimulus(0, 1, 19'h00001, ALL, BO2, BOE1, S_B, BO2, BOE1, "bus_gpio_hidden");
    applyStimulus(0, 0, GO2, ALL, BO2, BOE1, S_T, '0, ALL, "to_gpio_t1");
    applyStimulus(0, 0, GO2, ALL, BO2, BOE1, S_T, '0, ALL, "to_gpio_t2");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_G, GO2, '0, "gpio_back");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_G, GO2, '0, "gpio_hold1");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_G, GO2, '0, "gpio_hold2");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_G, GO2, '0, "gpio_hold3");

    // Single-cycle request pulse: full turnaround and a 4-cycle bus hold.
    applyStimulus(0, 1, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "pulse_t1");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "pulse_t2");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "pulse_b1");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "pulse_b2");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "pulse_b3");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "pulse_b4");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "pulse_r1");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "pulse_r2");
    applyStimulus(0, 0, GO2, ALL, BO1, BOE1, S_G, GO2, '0, "pulse_gpio");

    // Request toggling every cycle; hand-traced ownership per edge.
    pat = "GGGGTTBBBBBTTGGGGGT";
    for (int i = 0; i < pat.len(); i++) begin
      req = (i % 2 == 0) ? 1'b1 : 1'b0;
      case (pat[i])
        "G": begin st = S_G; eo = GO2; eb = '0; end
        "B": begin st = S_B; eo = BO1; eb = BOE1; end
        default: begin st = S_T; eo = '0; eb = ALL; end
      endcase
      applyStimulus(0, req, GO2, ALL, BO1, BOE1, st, eo, eb, $sformatf("toggle%0d", i));
    end

    // Reset during the second turnaround cycle, then restart with request high.
    applyStimulus(1, 1, GO2, ALL, BO1, BOE1, S_G, '0, ALL, "rst_mid_turn");
    applyStimulus(0, 1, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "restart_t1");
    applyStimulus(0, 1, GO2, ALL, BO1, BOE1, S_T, '0, ALL, "restart_t2");
    applyStimulus(0, 1, GO2, ALL, BO1, BOE1, S_B, BO1, BOE1, "restart_bus");

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("[TB] FAIL drain: got %0d pending required 0", expq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
